// File: rtl/latealu_scheduler.sv
// Round-robin issue of two requesters onto the shared one-cycle srl/sra unit,
// with in-flight ownership tracking and a one-entry response buffer per requester.
module latealu_scheduler #(
   parameter int unsigned TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [5:0]        req0_op,
   input  logic [31:0]       req0_a0,
   input  logic [31:0]       req0_a1,
   input  logic [TAG_W-1:0]  req0_tag,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [5:0]        req1_op,
   input  logic [31:0]       req1_a0,
   input  logic [31:0]       req1_a1,
   input  logic [TAG_W-1:0]  req1_tag,
   output logic [5:0]        alu_op,
   output logic [31:0]       alu_a0,
   output logic [31:0]       alu_a1,
   input  logic [31:0]       alu_result,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [31:0]       rsp0_result,
   output logic [TAG_W-1:0]  rsp0_tag,
   output logic              rsp0_illegal,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [31:0]       rsp1_result,
   output logic [TAG_W-1:0]  rsp1_tag,
   output logic              rsp1_illegal,
   output logic              busy
);
   localparam int unsigned OP_W   = 6;
   localparam int unsigned DATA_W = 32;
   localparam logic [OP_W-1:0] OP_NOP = 6'b000000;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;

   logic                   inflight_v;
   logic                   inflight_src;
   logic                   inflight_illegal;
   logic [TAG_W-1:0]       inflight_tag;
   logic                   last_grant;

   logic [1:0]             rsp_v;
   logic [1:0]             rsp_ill;
   logic [1:0][DATA_W-1:0] rsp_res;
   logic [1:0][TAG_W-1:0]  rsp_tg;
   logic [1:0]             rsp_rdy;

   logic [1:0]             elig;
   logic [1:0]             grant;
   logic [OP_W-1:0]        sel_op;
   logic [DATA_W-1:0]      sel_a0;
   logic [DATA_W-1:0]      sel_a1;
   logic [TAG_W-1:0]       sel_tag;
   logic                   sel_legal;
   logic                   issue_legal;

   assign rsp_rdy = {rsp1_ready, rsp0_ready};

   // A requester is blocked by its own in-flight op or by an undrained response.
   always_comb begin
      elig    = '0;
      grant   = '0;
      elig[0] = rst && req0_valid && !(inflight_v && !inflight_src) && (!rsp_v[0] || rsp0_ready);
      elig[1] = rst && req1_valid && !(inflight_v && inflight_src) && (!rsp_v[1] || rsp1_ready);
      if (elig == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end else begin
         grant = elig;
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Steer the granted request; anything not srl/sra issues as a zeroed nop.
   always_comb begin
      sel_op  = req0_op;
      sel_a0  = req0_a0;
      sel_a1  = req0_a1;
      sel_tag = req0_tag;
      if (grant[1]) begin
         sel_op  = req1_op;
         sel_a0  = req1_a0;
         sel_a1  = req1_a1;
         sel_tag = req1_tag;
      end
      sel_legal   = (sel_op == OP_SRL) || (sel_op == OP_SRA);
      issue_legal = (|grant) && sel_legal;
      alu_op      = issue_legal ? sel_op : OP_NOP;
      alu_a0      = issue_legal ? sel_a0 : '0;
      alu_a1      = issue_legal ? sel_a1 : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight_v       <= 1'b0;
         inflight_src     <= 1'b0;
         inflight_illegal <= 1'b0;
         inflight_tag     <= '0;
         last_grant       <= 1'b1;
      end else begin
         inflight_v <= |grant;
         if (|grant) begin
            inflight_src     <= grant[1];
            inflight_illegal <= !sel_legal;
            inflight_tag     <= sel_tag;
            last_grant       <= grant[1];
         end
      end
   end

   // A load and a drain of the same buffer never coincide; load takes priority anyway.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_v   <= '0;
         rsp_ill <= '0;
         rsp_res <= '0;
         rsp_tg  <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (inflight_v && (inflight_src == 1'(n))) begin
               rsp_v[n]   <= 1'b1;
               rsp_ill[n] <= inflight_illegal;
               rsp_res[n] <= inflight_illegal ? '0 : alu_result;
               rsp_tg[n]  <= inflight_tag;
            end else if (rsp_rdy[n]) begin
               rsp_v[n] <= 1'b0;
            end
         end
      end
   end

   assign rsp0_valid   = rsp_v[0];
   assign rsp0_result  = rsp_res[0];
   assign rsp0_tag     = rsp_tg[0];
   assign rsp0_illegal = rsp_ill[0];
   assign rsp1_valid   = rsp_v[1];
   assign rsp1_result  = rsp_res[1];
   assign rsp1_tag     = rsp_tg[1];
   assign rsp1_illegal = rsp_ill[1];

   assign busy = inflight_v | rsp_v[0] | rsp_v[1];

endmodule

// File: tb/tb_latealu_scheduler.sv
// Bench for latealu_scheduler: shift-unit stand-in, queue-based reference model,
// table vectors, directed multi-cycle sequences and a randomized run.
module tb_latealu_scheduler;
   localparam int unsigned TAG_W = 4;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_SRA = 6'b000011;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        rv;
   logic [1:0]        rrdy;
   logic [5:0]        rop [2];
   logic [31:0]       ra0 [2];
   logic [31:0]       ra1 [2];
   logic [TAG_W-1:0]  rtag [2];
   logic [5:0]        alu_op;
   logic [31:0]       alu_a0, alu_a1;
   logic [31:0]       alu_result = '0;
   logic [1:0]        rsp_ready;
   logic [1:0]        rsp_valid;
   logic [31:0]       rsp_res [2];
   logic [TAG_W-1:0]  rsp_tag [2];
   logic [1:0]        rsp_ill;
   logic              busy;

   latealu_scheduler #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(rv[0]), .req0_ready(rrdy[0]), .req0_op(rop[0]), .req0_a0(ra0[0]),
      .req0_a1(ra1[0]), .req0_tag(rtag[0]),
      .req1_valid(rv[1]), .req1_ready(rrdy[1]), .req1_op(rop[1]), .req1_a0(ra0[1]),
      .req1_a1(ra1[1]), .req1_tag(rtag[1]),
      .alu_op(alu_op), .alu_a0(alu_a0), .alu_a1(alu_a1), .alu_result(alu_result),
      .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_result(rsp_res[0]),
      .rsp0_tag(rsp_tag[0]), .rsp0_illegal(rsp_ill[0]),
      .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_result(rsp_res[1]),
      .rsp1_tag(rsp_tag[1]), .rsp1_illegal(rsp_ill[1]),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the shared late shift unit: one registered cycle, holds on nop.
   always @(posedge clk) begin
      if (alu_op == OP_SRL)      alu_result <= alu_a0 >> alu_a1[4:0];
      else if (alu_op == OP_SRA) alu_result <= 32'($signed(alu_a0) >>> alu_a1[4:0]);
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // {illegal, result} straight from the shift definitions.
   function automatic logic [32:0] ref_result(input logic [5:0] op, input logic [31:0] a0,
                                              input logic [31:0] a1);
      int unsigned amt = int'(a1 % 32);
      logic [31:0] lsr = a0 >> amt;
      if (op == OP_SRL) return {1'b0, lsr};
      if (op == OP_SRA) return {1'b0, a0[31] ? (lsr | ~(32'hFFFF_FFFF >> amt)) : lsr};
      return {1'b1, 32'h0};
   endfunction

   typedef struct {
      int               who;
      int               vis;
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      logic             ill;
   } ent_t;

   ent_t sb[$];
   int   cyc = 0;
   int   gcyc [2];
   int   lastw;
   int   last_g = -1;
   logic [1:0] s_rdy;

   function automatic int find_vis(input int n, input int t);
      for (int i = 0; i < sb.size(); i++)
         if (sb[i].who == n && sb[i].vis <= t) return i;
      return -1;
   endfunction

   task automatic model_reset();
      sb.delete();
      gcyc[0] = -10;
      gcyc[1] = -10;
      lastw   = 1;
      last_g  = -1;
   endtask

   // One cycle: check every output against the model mid-cycle, then advance.
   task automatic tick();
      int          vi [2];
      logic        ev [2];
      logic        el [2];
      int          g;
      logic [32:0] r;
      logic [5:0]  eop;
      logic [31:0] ea0, ea1;
      logic        eb;
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         vi[n] = find_vis(n, cyc);
         ev[n] = (vi[n] >= 0);
         el[n] = rv[n] && (gcyc[n] != cyc - 1) && (!ev[n] || rsp_ready[n]);
      end
      g = -1;
      if (el[0] && el[1]) g = 1 - lastw;
      else if (el[0])     g = 0;
      else if (el[1])     g = 1;
      s_rdy = rrdy;
      chk("req0_ready", 32'(rrdy[0]), 32'(g == 0));
      chk("req1_ready", 32'(rrdy[1]), 32'(g == 1));
      eop = '0; ea0 = '0; ea1 = '0; r = '0;
      if (g >= 0) begin
         r = ref_result(rop[g], ra0[g], ra1[g]);
         if (!r[32]) begin
            eop = rop[g]; ea0 = ra0[g]; ea1 = ra1[g];
         end
      end
      chk("alu_op", 32'(alu_op), 32'(eop));
      chk("alu_a0", alu_a0, ea0);
      chk("alu_a1", alu_a1, ea1);
      eb = (gcyc[0] == cyc - 1) || (gcyc[1] == cyc - 1) || ev[0] || ev[1];
      chk("busy", 32'(busy), 32'(eb));
      for (int n = 0; n < 2; n++) begin
         chk($sformatf("rsp%0d_valid", n), 32'(rsp_valid[n]), 32'(ev[n]));
         if (ev[n]) begin
            chk($sformatf("rsp%0d_result", n), rsp_res[n], sb[vi[n]].res);
            chk($sformatf("rsp%0d_tag", n), 32'(rsp_tag[n]), 32'(sb[vi[n]].tag));
            chk($sformatf("rsp%0d_illegal", n), 32'(rsp_ill[n]), 32'(sb[vi[n]].ill));
         end
      end
      for (int n = 0; n < 2; n++) begin
         if (ev[n] && rsp_ready[n]) sb.delete(find_vis(n, cyc));
      end
      if (g >= 0) begin
         gcyc[g] = cyc;
         lastw   = g;
         sb.push_back('{who: g, vis: cyc + 2, res: r[31:0], tag: rtag[g], ill: r[32]});
      end
      last_g = g;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rv = 2'b01; rop[0] = OP_SRL; ra0[0] = 32'h1234_5678; ra1[0] = 32'd1; rtag[0] = 4'd2;
      rsp_ready = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req0_ready", 32'(rrdy[0]), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_a0", alu_a0, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp_valid[1]), 32'd0);
      chk("rst_rsp0_result", rsp_res[0], 32'd0);
      chk("rst_rsp1_tag", 32'(rsp_tag[1]), 32'd0);
      rv = '0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic set_req(input int n, input logic [5:0] op, input logic [31:0] a0,
                          input logic [31:0] a1, input logic [TAG_W-1:0] tag);
      rv[n] = 1'b1; rop[n] = op; ra0[n] = a0; ra1[n] = a1; rtag[n] = tag;
   endtask

   typedef struct {
      int               who;
      logic [5:0]       op;
      logic [31:0]      a0;
      logic [31:0]      a1;
      logic [TAG_W-1:0] tag;
      logic [31:0]      res;
      logic             ill;
   } vec_t;

   vec_t vt [8];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tg [2];
      vt[0] = '{0, 6'b000010, 32'h8000_0000, 32'h0000_0004, 4'd3,  32'h0800_0000, 1'b0};
      vt[1] = '{1, 6'b000011, 32'h8000_0000, 32'h0000_0024, 4'd10, 32'hF800_0000, 1'b0};
      vt[2] = '{0, 6'b000000, 32'hFFFF_FFFF, 32'h0000_0000, 4'd1,  32'h0000_0000, 1'b1};
      vt[3] = '{1, 6'b000010, 32'hDEAD_BEEF, 32'h0000_0000, 4'd2,  32'hDEAD_BEEF, 1'b0};
      vt[4] = '{0, 6'b000011, 32'h7FFF_FFFF, 32'h0000_001F, 4'd4,  32'h0000_0000, 1'b0};
      vt[5] = '{1, 6'b000011, 32'hFFFF_FFFF, 32'h0000_001F, 4'd5,  32'hFFFF_FFFF, 1'b0};
      vt[6] = '{0, 6'b000010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6,  32'h0000_0001, 1'b0};
      vt[7] = '{1, 6'b000001, 32'h1234_5678, 32'h0000_0003, 4'd15, 32'h0000_0000, 1'b1};
      for (int n = 0; n < 2; n++) begin
         rop[n] = '0; ra0[n] = '0; ra1[n] = '0; rtag[n] = '0;
      end
      rv = '0;
      rsp_ready = 2'b11;
      do_reset();

      // Contention: both always valid, grants alternate starting with req0.
      tg[0] = 0; tg[1] = 0;
      for (int i = 0; i < 8; i++) begin
         for (int n = 0; n < 2; n++)
            set_req(n, (n == 0) ? OP_SRL : OP_SRA, 32'hF000_0000 ^ (32'(tg[n]) << 8),
                    32'(tg[n] + n), 4'(tg[n]));
         tick();
         chk("rr_order", 32'(s_rdy), (i % 2 == 0) ? 32'd1 : 32'd2);
         if (last_g >= 0) tg[last_g]++;
      end
      rv = '0;
      repeat (3) tick();

      // Table vectors: one request at a time, response checked at T+2.
      foreach (vt[k]) begin
         set_req(vt[k].who, vt[k].op, vt[k].a0, vt[k].a1, vt[k].tag);
         tick();
         chk($sformatf("vec%0d_ready", k), 32'(s_rdy[vt[k].who]), 32'd1);
         rv = '0;
         chk($sformatf("vec%0d_busy_t1", k), 32'(busy), 32'd1);
         tick();
         chk($sformatf("vec%0d_rsp_valid", k), 32'(rsp_valid[vt[k].who]), 32'd1);
         chk($sformatf("vec%0d_result", k), rsp_res[vt[k].who], vt[k].res);
         chk($sformatf("vec%0d_tag", k), 32'(rsp_tag[vt[k].who]), 32'(vt[k].tag));
         chk($sformatf("vec%0d_illegal", k), 32'(rsp_ill[vt[k].who]), 32'(vt[k].ill));
         tick();
         tick();
      end

      // Backpressure on requester 0 while requester 1 keeps issuing.
      rsp_ready = 2'b10;
      set_req(0, OP_SRL, 32'h0000_0100, 32'd4, 4'd5);
      tick();
      rv[0] = 1'b0;
      tick();
      tick();
      set_req(0, OP_SRL, 32'h0000_F000, 32'd8, 4'd9);
      tg[1] = 3;
      for (int i = 0; i < 4; i++) begin
         set_req(1, OP_SRA, 32'h8000_0000 | 32'(tg[1]), 32'(tg[1]), 4'(tg[1]));
         tick();
         chk("bp_req0_blocked", 32'(s_rdy[0]), 32'd0);
         if (last_g == 1) tg[1]++;
      end
      rsp_ready = 2'b11;
      set_req(1, OP_SRA, 32'h8000_0000 | 32'(tg[1]), 32'(tg[1]), 4'(tg[1]));
      tick();
      chk("bp_req0_granted", 32'(s_rdy[0]), 32'd1);
      rv[0] = 1'b0;
      if (last_g == 1) tg[1]++;
      chk("bp_old_drained", 32'(rsp_valid[0]), 32'd0);
      set_req(1, OP_SRA, 32'h8000_0000 | 32'(tg[1]), 32'(tg[1]), 4'(tg[1]));
      tick();
      chk("bp_new_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_new_tag", 32'(rsp_tag[0]), 32'd9);
      chk("bp_new_result", rsp_res[0], 32'h0000_00F0);
      rv = '0;
      repeat (3) tick();

      // Reset the cycle after a grant: the in-flight op must vanish.
      set_req(0, OP_SRL, 32'hFFFF_0000, 32'd16, 4'd7);
      tick();
      rv = '0;
      rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_rsp0_stays_low", 32'(rsp_valid[0]), 32'd0);
      model_reset();
      rst = 1'b1;
      set_req(0, OP_SRL, 32'h0000_0010, 32'd1, 4'd1);
      set_req(1, OP_SRL, 32'h0000_0020, 32'd1, 4'd2);
      tick();
      chk("post_reset_tie", 32'(s_rdy), 32'd1);
      rv = '0;
      repeat (3) tick();

      // Randomized traffic; stalled requesters hold their request.
      for (int i = 0; i < 400; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!(rv[n] && last_g != n)) begin
               int unsigned sel = $urandom % 8;
               rv[n]   = ($urandom % 4) != 0;
               rop[n]  = (sel < 3) ? OP_SRL : (sel < 6) ? OP_SRA : 6'($urandom);
               ra0[n]  = $urandom;
               ra1[n]  = $urandom;
               rtag[n] = 4'($urandom);
            end
         end
         rsp_ready = 2'(($urandom % 4 != 0) ? 1 : 0) | (($urandom % 4 != 0) ? 2'b10 : 2'b00);
         tick();
      end
      rv = '0;
      rsp_ready = 2'b11;
      repeat (4) tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/latealu_scheduler.md
Name: latealu_scheduler

Overview:
Shares the single late-stage shift unit (srl/sra, one registered cycle of latency, no valid or handshake of its own) between two requesters. The scheduler round-robin arbitrates issue, drives the unit's op/a0/a1 inputs, and tracks which requester each in-flight op belongs to. It routes each result into a per-requester one-entry response buffer with valid/ready backpressure. It sits between the issue stage and the late ALU in the pipeline.

Parameters:
TAG_W, 4, width of the requester-supplied tag returned with each result.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
reqN_valid  input  1  request valid (N = 0, 1)
reqN_ready  output  1  request accepted this cycle
reqN_op  input  6  shift op: 6'b000010 = srl, 6'b000011 = sra
reqN_a0  input  32  value to shift
reqN_a1  input  32  shift amount; only [4:0] used
reqN_tag  input  TAG_W  opaque tag
alu_op  output  6  op to shared unit
alu_a0  output  32  a0 to shared unit
alu_a1  output  32  a1 to shared unit
alu_result  input  32  unit result, valid the cycle after issue
rspN_valid  output  1  response valid
rspN_ready  input  1  response consumed
rspN_result  output  32  shift result
rspN_tag  output  TAG_W  tag of the completed request
rspN_illegal  output  1  op was not srl/sra
busy  output  1  any op in flight or any response buffered

Behaviour:
- Reset (rst low, async): inflight_v, inflight_src, and inflight_tag/illegal cleared. rspN_valid, result, tag and illegal cleared to 0. RR pointer set so req0 wins the first tie. busy = 0. While in reset, reqN_ready = 0 and alu_* = 0. Ops in flight at reset are dropped; their responses never appear.
- Eligibility at cycle T: elig_N = reqN_valid && !(inflight_v && inflight_src==N) && (!rspN_valid || rspN_ready).
- Grant: at most one per cycle. If only one requester is eligible, it is granted. If both are eligible, the one not granted most recently is granted. The pointer updates only on a grant.
- reqN_ready = grant_N (combinational). A transfer occurs when valid && ready. Requesters hold their inputs stable while valid && !ready.
- Issue at T: for a legal op, alu_op/a0/a1 = the granted request. For an illegal op, or when there is no grant, alu_op = 6'b000000 and alu_a0 = alu_a1 = 0; the unit holds its previous result.
- At edge E(T): inflight_v = grant, inflight_src = N, and the tag and illegal flag are latched.
- Cycle T+1: alu_result carries the result. At edge E(T+1), if inflight_v, the response buffer of inflight_src loads alu_result, or 0 if illegal, plus tag and illegal; rsp valid is set.
- Latency: response is visible at T+2 (issue to rsp_valid is 2 cycles).
- Throughput: shared unit up to 1 op/cycle. Each requester is limited to 1 op per 2 cycles because its own in-flight op blocks it.
- Response buffer: rspN_valid clears on rspN_valid && rspN_ready unless a new load occurs on the same edge. That case cannot happen, because eligibility forbids it; the bench asserts it never does.
- Expected unit arithmetic, checked by bench: srl is logical a0 >> a1[4:0]; sra is arithmetic. a1[31:5] is ignored.
- busy = inflight_v | rsp0_valid | rsp1_valid.
- Simultaneous events: a grant and a drain of the same requester's buffer in the same cycle is legal. A grant to requester A while B's op is in flight is legal.

Test Plan:
- Single srl: req0 op=000010, a0=0x80000000, a1=4, tag=3 at T -> req0_ready=1 at T; alu_op=000010 at T; rsp0_valid at T+2 with result 0x08000000, tag 3, illegal 0; busy high T+1..T+2.
- sra with ignored high bits: req1 op=000011, a0=0x80000000, a1=0x00000024 -> rsp1_result=0xF8000000.
- Contention: both requesters continuously valid, rsp ready tied 1 -> grants go 0,1,0,1 (req0 first after reset); one alu issue per cycle; each response 2 cycles after its grant; tags preserved in order per requester.
- Backpressure: rsp0_ready=0 with rsp0_valid=1 and req0 valid -> req0_ready stays 0 while req1 continues to be served. Raise rsp0_ready -> req0 granted that same cycle; the old response drains and the new one appears 2 cycles later.
- Illegal op: req0 op=000000, a0=0xFFFFFFFF -> granted; alu_op=000000, alu_a0=0; rsp0_result=0, rsp0_illegal=1.
- Reset mid-operation: assert rst low the cycle after a grant -> rsp valid never rises, busy=0 immediately. After release, the first tie is granted to req0.
